mmio_uart_tx: RTL and testbench
===============================

Name: mmio_uart_tx

Overview:
Memory-mapped UART transmitter on the processor's data-memory bus, alongside the LED and switch registers at 0x8000/0x8008. It consumes the datapath's DM_addr, DM_writeData and DM_writeEnable. Software writes bytes into a small TX FIFO and polls a status register. The block returns read data plus a hit flag, which the top level muxes into the datapath read path the same way the switch register is muxed.

Parameters:
N, 64, bus data/address width
CLKS_PER_BIT, 868, clk cycles per serial bit (legal values >= 2)
DEPTH, 4, TX FIFO entries (power of 2, >= 2)
TXDATA_ADDR, 64'h8010, write-only data register address
STATUS_ADDR, 64'h8018, read status register address

Ports:
clk  input  1  processor clock (same divided clock as datapath/dmem)
reset  input  1  synchronous active-high reset
addr  input  N  DM_addr from datapath
writeData  input  N  DM_writeData from datapath
memWrite  input  1  DM_writeEnable
memRead  input  1  DM_readEnable
readData  output  N  status value when readHit, else 0 (combinational)
readHit  output  1  addr == STATUS_ADDR (combinational, independent of memRead)
tx  output  1  serial line, registered, idle high

Behaviour:
- Reset: synchronous, active-high.
  - Sampled on posedge clk; reset is dominant over every other event.
  - Reset sets: FIFO empty (rd/wr pointers and count = 0), overflow = 0, FSM = IDLE, baud counter = 0, bit index = 0, tx = 1.
  - A frame in progress when reset is asserted is abandoned; tx is 1 on the first edge after reset.
- Push: on posedge, if memWrite && addr == TXDATA_ADDR:
  - not full: writeData[7:0] is stored at the write pointer; pointer and count advance. Upper bits are ignored.
  - full: the byte is dropped and overflow is set (sticky). Full is evaluated on pre-edge state, so a same-edge pop does not rescue the push.
- Writes to STATUS_ADDR are ignored. Reads of TXDATA_ADDR do not hit.
- Status word: bit0 busy (FSM != IDLE or count != 0), bit1 full (count == DEPTH), bit2 overflow, bits[6:4] count (bits beyond count width are 0), all other bits 0.
- Overflow clear: cleared on posedge where memRead && addr == STATUS_ADDR. If an overflow push occurs on the same edge, set wins.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Simultaneous push and pop when not full: both happen and count is unchanged.
- FSM states: IDLE, START, DATA, STOP. Baud counter counts 0..CLKS_PER_BIT-1.
  - IDLE: tx = 1. If count != 0, pop the head byte into the shift register, go to START, tx <= 0, counter <= 0.
  - START: hold tx = 0. When counter == CLKS_PER_BIT-1, go to DATA, tx <= shift[0], bit index = 0.
  - DATA: each completed bit period shifts right and outputs the next bit, LSB first. After bit 7's period, go to STOP, tx <= 1.
  - STOP: hold tx = 1 for CLKS_PER_BIT cycles. At the end, if count != 0, pop and go directly to START (tx <= 0, no idle gap); else go to IDLE.
- Latency: push at edge k into an empty idle block gives tx = 0 after edge k+1. One frame is 10*CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- The byte being shifted is not counted in count. busy covers it via FSM state.

Test Plan:
- Reset/idle (CLKS_PER_BIT=4): hold reset 3 cycles, then release → tx=1; STATUS read gives readData=0, readHit=1; addr=0x8000 gives readHit=0, readData=0.
- Single byte: write 0x...A5 to 0x8010 at edge k → tx falls after edge k+1; line sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; busy=1 throughout, 0 after the stop bit ends.
- Back-to-back: write 0x55 then 0x0F on consecutive cycles → two 40-cycle frames with no idle cycle between; count reads 1 during the first frame, then 0.
- Overflow: while the first byte is shifting, write 5 more bytes → count=4, full=1, overflow=1, 5th byte never transmitted. STATUS read with memRead clears overflow on the next edge; full persists until a pop.
- Simultaneous push/pop at the STOP→START boundary with count=4 → push dropped, overflow set, count=3 after the edge.
- Reset mid-frame: assert reset during DATA bit 3 → tx=1 after that edge, count=0, busy=0; a subsequent write transmits normally.

Source files
------------

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: a small byte FIFO written through TXDATA_ADDR
// feeds an 8N1 serializer; STATUS_ADDR returns busy/full/overflow/count.
module mmio_uart_tx #(
    parameter int N = 64,
    parameter int CLKS_PER_BIT = 868,
    parameter int DEPTH = 4,
    parameter logic [N-1:0] TXDATA_ADDR = 'h8010,
    parameter logic [N-1:0] STATUS_ADDR = 'h8018
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] writeData,
    input  logic         memWrite,
    input  logic         memRead,
    output logic [N-1:0] readData,
    output logic         readHit,
    output logic         tx
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int BCW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_n;
    logic [BCW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]     bit_idx, bit_idx_n;
    logic [7:0]     shift, shift_n;
    logic           tx_n;

    logic [7:0]     fifo_mem [DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;
    logic           overflow;

    logic push_req, full, do_push, pop, baud_done, busy, status_rd;
    logic [2:0] count3;
    logic unused_bits;

    assign push_req    = memWrite && (addr == TXDATA_ADDR);
    assign status_rd   = memRead && (addr == STATUS_ADDR);
    assign full        = (count == CW'(DEPTH));
    assign do_push     = push_req && !full;
    assign baud_done   = (baud_cnt == BCW'(CLKS_PER_BIT - 1));
    assign busy        = (state != IDLE) || (count != '0);
    assign count3      = 3'(count);
    assign unused_bits = ^writeData[N-1:8];

    assign readHit  = (addr == STATUS_ADDR);
    assign readData = readHit ? {{(N-7){1'b0}}, count3, 1'b0, overflow, full, busy} : '0;

    // Serializer: the head byte is popped on leaving IDLE or at the end of a
    // stop bit, so consecutive frames run with no idle gap.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_n    = fifo_mem[rd_ptr];
                    state_n    = START;
                    tx_n       = 1'b0;
                    baud_cnt_n = '0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_n    = DATA;
                    tx_n       = shift[0];
                    bit_idx_n  = '0;
                    baud_cnt_n = '0;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_n = '0;
                    if (count != '0) begin
                        pop     = 1'b1;
                        shift_n = fifo_mem[rd_ptr];
                        state_n = START;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = IDLE;
                        tx_n    = 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            if (do_push && !pop)      count <= count + 1'b1;
            else if (pop && !do_push) count <= count - 1'b1;
            // A dropped push outranks a same-edge status read.
            if (push_req && full) overflow <= 1'b1;
            else if (status_rd)   overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) fifo_mem[wr_ptr] <= writeData[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx: a queue-based reference model predicts the
// line and status each cycle, and a frame decoder checks bytes against exp_q.
module tb_mmio_uart_tx;
    localparam int N = 64;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam logic [63:0] TX_A  = 64'h8010;
    localparam logic [63:0] ST_A  = 64'h8018;
    localparam logic [63:0] LED_A = 64'h8000;

    logic clk = 1'b0;
    logic reset, memWrite, memRead, readHit, tx;
    logic [N-1:0] addr, writeData, readData;

    always #5 clk = ~clk;

    mmio_uart_tx #(.N(N), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH),
                   .TXDATA_ADDR(TX_A), .STATUS_ADDR(ST_A)) dut (
        .clk(clk), .reset(reset), .addr(addr), .writeData(writeData),
        .memWrite(memWrite), .memRead(memRead), .readData(readData),
        .readHit(readHit), .tx(tx)
    );

    int checks = 0;
    int errors = 0;
    bit checks_on = 0;
    logic [7:0] exp_q[$];

    // Reference model state: pending bytes, when the shifter frees up, current frame.
    logic [7:0] mq[$];
    int edge_cnt = 0;
    int next_free = 0;
    int frame_start = 0;
    bit frame_valid = 0;
    logic [7:0] frame_byte = 8'h00;
    bit m_ovf = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : ref_model
        int pre;
        bit pushing;
        edge_cnt++;
        if (reset) begin
            mq.delete();
            exp_q.delete();
            m_ovf = 0;
            next_free = edge_cnt;
            frame_valid = 0;
        end else begin
            pre = mq.size();
            pushing = memWrite && (addr == TX_A);
            if (pre != 0 && edge_cnt >= next_free) begin
                frame_byte = mq.pop_front();
                frame_start = edge_cnt;
                frame_valid = 1;
                next_free = edge_cnt + FRAME;
            end
            if (pushing && pre < DEPTH) begin
                mq.push_back(writeData[7:0]);
                exp_q.push_back(writeData[7:0]);
            end
            if (pushing && pre == DEPTH) m_ovf = 1;
            else if (memRead && addr == ST_A) m_ovf = 0;
        end
    end

    function automatic logic exp_tx_f();
        int d, k;
        d = edge_cnt - frame_start;
        if (!frame_valid || d >= FRAME) return 1'b1;
        k = d / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return frame_byte[k-1];
        return 1'b1;
    endfunction

    function automatic logic [63:0] exp_status();
        logic [63:0] s;
        s = '0;
        s[0] = (edge_cnt < next_free) || (mq.size() != 0);
        s[1] = (mq.size() == DEPTH);
        s[2] = m_ovf;
        s[6:4] = 3'(mq.size());
        return s;
    endfunction

    // Cycle-level monitor for line and status read port.
    always @(negedge clk) begin
        if (checks_on) begin
            check("tx_line", {63'b0, tx}, {63'b0, exp_tx_f()});
            check("read_hit", {63'b0, readHit}, {63'b0, (addr == ST_A)});
            check("read_data", readData, (addr == ST_A) ? exp_status() : 64'b0);
        end
    end

    // Frame decoder: samples mid-bit and pops the scoreboard on each stop bit.
    int pos = 0;
    bit in_frame = 0;
    logic [7:0] rx = 8'h00;
    always @(negedge clk) begin
        if (reset || !checks_on) in_frame = 0;
        else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1;
                pos = 0;
            end
        end else pos++;
        if (in_frame) begin
            if (pos >= CPB + CPB/2 && pos < 9*CPB && ((pos - CPB/2) % CPB) == 0)
                rx[(pos - CPB/2)/CPB - 1] = tx;
            if (pos == 9*CPB + CPB/2) begin
                check("stop_bit", {63'b0, tx}, 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected actual=%h expected=none t=%0t", rx, $time);
                end else begin
                    check("frame_byte", {56'b0, rx}, {56'b0, exp_q.pop_front()});
                end
                in_frame = 0;
            end
        end
    end

    task automatic drive(logic r, logic [63:0] a, logic w, logic rd, logic [63:0] d);
        reset = r; addr = a; memWrite = w; memRead = rd; writeData = d;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic idle(int n);
        repeat (n) drive(1'b0, ST_A, 1'b0, 1'b0, rand64());
    endtask

    task automatic write_byte(logic [7:0] b);
        logic [63:0] d;
        d = rand64();
        d[7:0] = b;
        drive(1'b0, TX_A, 1'b1, 1'b0, d);
    endtask

    initial begin
        int guard;
        int r;
        reset = 1'b1; addr = ST_A; memWrite = 1'b0; memRead = 1'b0; writeData = '0;
        @(negedge clk);
        #1;
        checks_on = 1;
        drive(1'b1, ST_A, 1'b0, 1'b0, '0);
        drive(1'b1, ST_A, 1'b0, 1'b0, '0);
        idle(2);
        drive(1'b0, LED_A, 1'b0, 1'b1, '0);
        drive(1'b0, TX_A, 1'b0, 1'b1, '0);
        idle(2);

        write_byte(8'hA5);
        idle(45);

        write_byte(8'h55);
        write_byte(8'h0F);
        idle(85);

        write_byte(8'h11);
        idle(2);
        repeat (5) write_byte(8'($urandom));
        idle(3);
        drive(1'b0, ST_A, 1'b0, 1'b1, rand64());
        idle(3);
        idle(6 * FRAME);

        write_byte(8'h81);
        repeat (4) write_byte(8'($urandom));
        idle(36);
        write_byte(8'hEE);
        idle(4);
        idle(5 * FRAME);

        write_byte(8'hC3);
        idle(17);
        drive(1'b1, ST_A, 1'b0, 1'b0, rand64());
        idle(3);
        write_byte(8'h3C);
        idle(FRAME + 5);

        repeat (600) begin
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 299) == 0) drive(1'b1, ST_A, 1'b0, 1'b0, rand64());
            else if (r <= 3) write_byte(8'($urandom));
            else if (r == 4) drive(1'b0, ST_A, 1'b1, 1'($urandom), rand64());
            else if (r == 5) drive(1'b0, ST_A, 1'b0, 1'b1, rand64());
            else if (r == 6) drive(1'b0, LED_A, 1'($urandom), 1'($urandom), rand64());
            else if (r == 7) drive(1'b0, {32'b0, $urandom} | 64'h10000, 1'($urandom), 1'($urandom), rand64());
            else idle(1);
        end

        guard = 0;
        while ((mq.size() != 0 || edge_cnt < next_free) && guard < 2000) begin
            idle(1);
            guard++;
        end
        check("drain_in_time", {63'b0, (guard < 2000)}, 64'd1);
        idle(3);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
